// File: rtl/btn_chatter_gen_pkg.sv
// Shared types and constants for the pushbutton chatter generator.
// The state encoding and LFSR definition live here so every user sees one copy.
package btn_chatter_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_BNC,
    HOLD,
    REL_BNC
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Taps 16,14,13,11 expressed as bit positions of a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {^(q & LFSR_TAPS), q[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used as the chatter source; advances only when EN is high.
// Reset loads the non-zero seed, so the register can never reach the all-zero lockup state.
module lfsr16
  import btn_chatter_gen_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  output logic [15:0] Q
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= LFSR_SEED;
    end else if (EN) begin
      Q <= lfsr_next(Q);
    end
  end

endmodule

// File: rtl/btn_chatter_gen.sv
// Emulates one bouncy press/release of a mechanical pushbutton per START request,
// producing a raw button level suitable for exercising a debouncer.
module btn_chatter_gen
  import btn_chatter_gen_pkg::*;
#(
  parameter int unsigned STEP_CYC     = 100000,
  parameter int unsigned BOUNCE_STEPS = 8,
  parameter int unsigned HOLD_CYC     = 10000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic START,
  output logic BTNSIM,
  output logic BUSY,
  output logic DONE
);

  localparam int unsigned SW = $clog2(STEP_CYC);
  localparam int unsigned IW = $clog2(BOUNCE_STEPS);
  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(BOUNCE_STEPS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  state_t        state;
  logic [SW-1:0] stepcnt;
  logic [IW-1:0] stepidx;
  logic [HW-1:0] holdcnt;
  logic          armed;

  logic          bouncing;
  logic          tick;
  logic          laststep;
  logic          lfsren;
  logic [15:0]   lfsrq;
  logic          unused_lfsr;

  assign bouncing    = (state == PRESS_BNC) || (state == REL_BNC);
  assign tick        = bouncing && (stepcnt == STEP_LAST);
  assign laststep    = (stepidx == IDX_LAST);
  assign lfsren      = tick && !laststep;
  assign unused_lfsr = ^lfsrq[15:1];

  lfsr16 u_lfsr (
    .CLK  (CLK),
    .RST_N(RST_N),
    .EN   (lfsren),
    .Q    (lfsrq)
  );

  // armed stays low for the first edge after reset release so a START racing the release is dropped
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      BTNSIM  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      stepcnt <= '0;
      stepidx <= '0;
      holdcnt <= '0;
      armed   <= 1'b0;
    end else begin
      armed <= 1'b1;
      DONE  <= 1'b0;
      case (state)
        IDLE: begin
          BTNSIM <= 1'b0;
          if (START && armed && !DONE) begin
            state   <= PRESS_BNC;
            BUSY    <= 1'b1;
            stepcnt <= '0;
            stepidx <= '0;
          end
        end

        PRESS_BNC, REL_BNC: begin
          if (tick) begin
            stepcnt <= '0;
            if (laststep) begin
              stepidx <= '0;
              holdcnt <= '0;
              if (state == PRESS_BNC) begin
                BTNSIM <= 1'b1;
                state  <= HOLD;
              end else begin
                BTNSIM <= 1'b0;
                BUSY   <= 1'b0;
                DONE   <= 1'b1;
                state  <= IDLE;
              end
            end else begin
              BTNSIM  <= lfsrq[0];
              stepidx <= stepidx + 1'b1;
            end
          end else begin
            stepcnt <= stepcnt + 1'b1;
          end
        end

        HOLD: begin
          BTNSIM <= 1'b1;
          if (holdcnt == HOLD_LAST) begin
            stepcnt <= '0;
            state   <= REL_BNC;
          end else begin
            holdcnt <= holdcnt + 1'b1;
          end
        end

        default: begin
          BTNSIM <= 1'b0;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/btn_chatter_gen.md
BTN_CHATTER_GEN -- requirements
Module: btn_chatter_gen

Interface
REQ-001 SHALL have parameter STEP_CYC, default 100000, meaning clock cycles per chatter step (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter BOUNCE_STEPS, default 8, meaning chatter steps per edge; legal range 2..255.
REQ-003 SHALL have parameter HOLD_CYC, default 10000000, meaning stable-high cycles between edges (100 ms); legal range 1..2^24.
REQ-004 SHALL have port CLK, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port START, input, 1 bit: single-cycle request to emulate one complete press/release.
REQ-007 SHALL have port BTNSIM, output, 1 bit: emulated raw pushbutton level, intended to drive a debouncer's button input.
REQ-008 SHALL have port BUSY, output, 1 bit: high while an emulation is in progress.
REQ-009 SHALL have port DONE, output, 1 bit: one-cycle pulse marking completion.

Function
REQ-010 SHALL implement FSM states IDLE, PRESS_BNC, HOLD, REL_BNC, with all outputs registered.
REQ-011 In IDLE, START=1 SHALL move to PRESS_BNC on the next edge, clear the step and cycle counters, and set BUSY=1 on that same edge.
REQ-012 START SHALL be ignored while BUSY=1; there is no queueing.
REQ-013 A step counter SHALL generate a step tick every STEP_CYC cycles; in bounce states the tick SHALL fire when the counter equals STEP_CYC-1, and the counter SHALL wrap to 0.
REQ-014 In PRESS_BNC, each step tick for steps 0..BOUNCE_STEPS-2 SHALL set BTNSIM to lfsr[0] and advance the LFSR one position.
REQ-015 The final tick in PRESS_BNC SHALL force BTNSIM=1 and move to HOLD.
REQ-016 HOLD SHALL keep BTNSIM=1 for exactly HOLD_CYC cycles, then move to REL_BNC.
REQ-017 REL_BNC SHALL mirror PRESS_BNC, except that the final tick forces BTNSIM=0 and moves to IDLE.
REQ-018 On entry to IDLE from REL_BNC, the FSM SHALL pulse DONE=1 for one cycle and drop BUSY=0 on the same edge.
REQ-019 BTNSIM SHALL be 0 in IDLE at all times.
REQ-020 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1; it advances only on bounce-state step ticks and is never all-zero.
REQ-021 Total BUSY duration SHALL be exactly 2*BOUNCE_STEPS*STEP_CYC + HOLD_CYC cycles.
REQ-022 START asserted on the same cycle as DONE SHALL be ignored; a new run needs START while BUSY=0.

Reset
REQ-023 RST_N=0 SHALL asynchronously force state=IDLE, BTNSIM=0, BUSY=0, DONE=0, counters=0, and LFSR=seed.
REQ-024 Reset asserted mid-operation SHALL abort the run, with no DONE pulse.
REQ-025 Reset release SHALL be synchronized externally; the block SHALL ignore START on the first edge after release.

Structure
REQ-026 A shared package SHALL hold the state enumeration (2-bit), LFSR seed, and tap constants.
REQ-027 The LFSR SHALL be a sub-module lfsr16 with ports CLK, RST_N, EN, and Q[15:0].
REQ-028 Counter widths SHALL be derived from parameters via clog2, with no hard-coded widths.

Verification
REQ-029 Bench parameters SHALL be STEP_CYC=4, BOUNCE_STEPS=4, HOLD_CYC=20.
REQ-030 Nominal run: START pulse from IDLE -> BUSY high for exactly 52 cycles, DONE single pulse, BTNSIM=1 during all 20 HOLD cycles, BTNSIM=0 afterward.
REQ-031 Bounce content: two back-to-back runs after one reset -> press-phase BTNSIM values match a reference LFSR (seed ACE1) bit sequence; last press step=1; last release step=0.
REQ-032 START during BUSY at cycles 1, 20, and 51 -> no effect; BUSY/DONE timing identical to the nominal run.
REQ-033 RST_N low during HOLD -> BTNSIM=0 and BUSY=0 immediately (asynchronous), no DONE; a subsequent START reproduces the nominal run from seed.
REQ-034 Loopback: BTNSIM into the team debounce block (shortened tick) -> exactly one clean pulse per run across 10 runs.
REQ-035 START coincident with the DONE cycle -> ignored; BUSY stays 0 on the next cycle.
